// File: rtl/logicnet_lut_layer.sv
// Layer of independent LUT neurons: each neuron looks up its FANIN-bit input slice in a
// programmable flop table. Optional input register stage under macro LOGICNET_LUT_IN_REG_EN.
module logicnet_lut_layer #(
  parameter int NEURONS  = 4,
  parameter int FANIN    = 8,
  parameter int OUT_BITS = 1,
  localparam int NW      = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NEURONS*FANIN-1:0]     in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NEURONS*OUT_BITS-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         cfg_req,
  input  logic                         cfg_we,
  input  logic [NW-1:0]                cfg_neuron,
  input  logic [FANIN-1:0]             cfg_addr,
  input  logic [OUT_BITS-1:0]          cfg_wdata,
  output logic                         cfg_active
);

  localparam int DEPTH = 1 << FANIN;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic                          out_valid_q, out_valid_d;
  logic [NEURONS*OUT_BITS-1:0]   out_data_q, out_data_d;
  logic                          cfg_active_q, cfg_active_d;
  logic [OUT_BITS-1:0]           tbl_q [NEURONS][DEPTH];
  logic [OUT_BITS-1:0]           tbl_d [NEURONS][DEPTH];

  logic                          advance_s;
  logic                          in_ready_s;
  logic                          xfer_s;
  logic                          empty_s;
  logic                          we_ok_s;
  logic [NEURONS*FANIN-1:0]      lk_addr_s;
  logic [NEURONS*OUT_BITS-1:0]   lut_s;

`ifdef LOGICNET_LUT_IN_REG_EN
  logic                          s1_valid_q, s1_valid_d;
  logic [NEURONS*FANIN-1:0]      s1_data_q, s1_data_d;
  assign lk_addr_s = s1_data_q;
`else
  assign lk_addr_s = in_data;
`endif

  // Table lookup for every neuron from its own address slice
  always_comb begin
    lut_s = {(NEURONS*OUT_BITS){1'b0}};
    for (int n = 0; n < NEURONS; n++) begin
      lut_s[n*OUT_BITS +: OUT_BITS] = tbl_q[n][lk_addr_s[n*FANIN +: FANIN]];
    end
  end

  // Table write decode; only LOAD writes to an existing neuron land
  always_comb begin
    we_ok_s = (state_q == LOAD) && cfg_we &&
              ({1'b0, cfg_neuron} < (NW+1)'(NEURONS));
    for (int n = 0; n < NEURONS; n++) begin
      for (int a = 0; a < DEPTH; a++) begin
        tbl_d[n][a] = (we_ok_s && (cfg_neuron == NW'(n)) && (cfg_addr == FANIN'(a)))
                      ? cfg_wdata : tbl_q[n][a];
      end
    end
  end

  // Handshake, datapath and FSM next-state
  always_comb begin
    advance_s    = !out_valid_q || out_ready;
    in_ready_s   = (state_q == RUN) && !cfg_req && advance_s;
    xfer_s       = in_valid && in_ready_s;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
`ifdef LOGICNET_LUT_IN_REG_EN
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    // Whole pipeline moves together, so a stalled output freezes stage 1 too
    if (advance_s) begin
      s1_valid_d  = xfer_s;
      s1_data_d   = xfer_s ? in_data : s1_data_q;
      out_valid_d = s1_valid_q;
      out_data_d  = s1_valid_q ? lut_s : out_data_q;
    end else begin
      s1_valid_d  = s1_valid_q;
    end
    empty_s      = advance_s && !s1_valid_q;
`else
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = lut_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    empty_s      = advance_s;
`endif
    case (state_q)
      RUN:     state_d = cfg_req ? DRAIN : RUN;
      DRAIN:   state_d = empty_s ? LOAD : DRAIN;
      LOAD:    state_d = cfg_req ? LOAD : RUN;
      default: state_d = RUN;
    endcase
    cfg_active_d = (state_d == LOAD);
  end

  // State, output and table registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      out_valid_q  <= 1'b0;
      out_data_q   <= {(NEURONS*OUT_BITS){1'b0}};
      cfg_active_q <= 1'b0;
`ifdef LOGICNET_LUT_IN_REG_EN
      s1_valid_q   <= 1'b0;
      s1_data_q    <= {(NEURONS*FANIN){1'b0}};
`endif
      for (int n = 0; n < NEURONS; n++) begin
        for (int a = 0; a < DEPTH; a++) begin
          tbl_q[n][a] <= {OUT_BITS{1'b0}};
        end
      end
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      cfg_active_q <= cfg_active_d;
`ifdef LOGICNET_LUT_IN_REG_EN
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
`endif
      for (int n = 0; n < NEURONS; n++) begin
        for (int a = 0; a < DEPTH; a++) begin
          tbl_q[n][a] <= tbl_d[n][a];
        end
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign cfg_active = cfg_active_q;

endmodule

// File: tb/tb_logicnet_lut_layer.sv
// Directed bench for logicnet_lut_layer (default build, latency 1); a second NEURONS=5
// instance exercises dropping of writes to nonexistent neurons.
module tb_logicnet_lut_layer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic [3:0]  out_data;
  logic        out_valid, out_ready;
  logic        cfg_req, cfg_we;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [0:0]  cfg_wdata;
  logic        cfg_active;

  logic [39:0] b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [4:0]  b_out_data;
  logic        b_out_valid, b_out_ready;
  logic        b_cfg_req, b_cfg_we;
  logic [2:0]  b_cfg_neuron;
  logic [7:0]  b_cfg_addr;
  logic [0:0]  b_cfg_wdata;
  logic        b_cfg_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logicnet_lut_layer u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_active(cfg_active)
  );

  logicnet_lut_layer #(.NEURONS(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .cfg_req(b_cfg_req), .cfg_we(b_cfg_we), .cfg_neuron(b_cfg_neuron), .cfg_addr(b_cfg_addr),
    .cfg_wdata(b_cfg_wdata), .cfg_active(b_cfg_active)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_data = 32'h0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_neuron = 2'd0; cfg_addr = 8'h00; cfg_wdata = 1'b0;
    b_in_data = 40'h0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    b_cfg_req = 1'b0; b_cfg_we = 1'b0; b_cfg_neuron = 3'd0; b_cfg_addr = 8'h00; b_cfg_wdata = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_cfg_active", 64'(cfg_active), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Zero input after reset -> zero output one cycle later
    in_data = 32'h0; in_valid = 1'b1;
    tick();
    chk("first_valid", 64'(out_valid), 64'd1);
    chk("first_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    tick();
    chk("first_drop", 64'(out_valid), 64'd0);

    // Program neuron 2 @84 and neuron 0 @FF; leave LOAD on the second write
    cfg_req = 1'b1;
    #1;
    chk("req_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("drain_cfg_active", 64'(cfg_active), 64'd0);
    tick();
    chk("load_cfg_active", 64'(cfg_active), 64'd1);
    cfg_we = 1'b1; cfg_neuron = 2'd2; cfg_addr = 8'h84; cfg_wdata = 1'b1;
    tick();
    cfg_neuron = 2'd0; cfg_addr = 8'hFF; cfg_req = 1'b0;
    tick();
    cfg_we = 1'b0;
    chk("run_cfg_active", 64'(cfg_active), 64'd0);
    in_data = 32'h0084_00FF; in_valid = 1'b1;
    tick();
    chk("prog_valid", 64'(out_valid), 64'd1);
    chk("prog_data", 64'(out_data), 64'h5);

    // Backpressure for 5 cycles, then back-to-back transfers
    out_ready = 1'b0; in_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", 64'(out_data), 64'h5);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1; in_data = 32'h0000_00FF;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("b2b_1", 64'({out_valid, out_data}), 64'h11);
    in_data = 32'h0084_0000;
    tick();
    chk("b2b_2", 64'({out_valid, out_data}), 64'h14);
    in_data = 32'h0;
    tick();
    chk("b2b_3", 64'({out_valid, out_data}), 64'h10);
    in_valid = 1'b0;
    tick();
    chk("b2b_end", 64'(out_valid), 64'd0);

    // cfg_req while an output is held: DRAIN until accepted
    out_ready = 1'b0; in_data = 32'h0000_00FF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; cfg_req = 1'b1;
    tick();
    chk("drain_hold_active", 64'(cfg_active), 64'd0);
    chk("drain_hold_out", 64'({out_valid, out_data}), 64'h11);
    tick();
    chk("drain_hold_active2", 64'(cfg_active), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("drain_done_active", 64'(cfg_active), 64'd1);
    chk("drain_done_valid", 64'(out_valid), 64'd0);

    // Write attempted in RUN must be ignored
    cfg_req = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_neuron = 2'd1; cfg_addr = 8'h00; cfg_wdata = 1'b1;
    tick();
    cfg_we = 1'b0; in_data = 32'h0; in_valid = 1'b1;
    tick();
    chk("run_we_ignored", 64'({out_valid, out_data}), 64'h10);
    in_valid = 1'b0;

    // Reset pulsed mid-LOAD clears tables and pending writes
    cfg_req = 1'b1;
    tick(); tick();
    chk("load2_active", 64'(cfg_active), 64'd1);
    cfg_we = 1'b1; cfg_neuron = 2'd3; cfg_addr = 8'h10; cfg_wdata = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_active", 64'(cfg_active), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    tick();
    rst = 1'b0; cfg_we = 1'b0; cfg_req = 1'b0;
    in_data = 32'h1084_00FF; in_valid = 1'b1;
    tick();
    chk("post_rst_lookup", 64'({out_valid, out_data}), 64'h10);
    in_valid = 1'b0;
    tick();

    // NEURONS=5 instance: neuron indices 5 and 7 must be dropped, 4 accepted
    b_cfg_req = 1'b1;
    tick(); tick();
    chk("b_load_active", 64'(b_cfg_active), 64'd1);
    b_cfg_we = 1'b1; b_cfg_neuron = 3'd5; b_cfg_addr = 8'h00; b_cfg_wdata = 1'b1;
    tick();
    b_cfg_neuron = 3'd7;
    tick();
    b_cfg_neuron = 3'd4; b_cfg_addr = 8'h01;
    tick();
    b_cfg_we = 1'b0; b_cfg_req = 1'b0;
    tick();
    b_in_data = 40'h0; b_in_valid = 1'b1;
    tick();
    chk("b_dropped", 64'({b_out_valid, b_out_data}), 64'h20);
    b_in_data = 40'h01_0000_0000;
    tick();
    chk("b_written", 64'({b_out_valid, b_out_data}), 64'h30);
    b_in_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
